// File: rtl/wca_sync_event_arbiter.sv
// wca_sync_event_arbiter: synchronizes async inputs, queues qualified edges, round-robins them onto one event port
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   in                                    raw asynchronous inputs
//   rise_en, fall_en                      per-channel edge qualifiers (quasi-static)
//   sync_out                              synchronized levels (last synchronizer stage)
//   pending                               per-channel pending-event flags
//   evt_valid, evt_ready                  event handshake
//   evt_id, evt_level, evt_ovf, evt_time  event word
// Define WCA_SYNC_EVT_TIMESTAMP_EN to latch a 16-bit timestamp per edge; otherwise evt_time is 0.
module wca_sync_event_arbiter #(
   parameter int NUM_IN      = 4,
   parameter int IDW         = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_IN-1:0] in,
   input  logic [NUM_IN-1:0] rise_en,
   input  logic [NUM_IN-1:0] fall_en,
   output logic [NUM_IN-1:0] sync_out,
   output logic [NUM_IN-1:0] pending,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [IDW-1:0]    evt_id,
   output logic              evt_level,
   output logic              evt_ovf,
   output logic [15:0]       evt_time
);
   localparam int PW = $clog2(SYNC_STAGES + 2);
   logic [SYNC_STAGES*NUM_IN-1:0] chain;
   logic [NUM_IN-1:0] hist, qual, level, ovf, hi, req, oh, gnt;
   logic [IDW-1:0][NUM_IN-1:0] idm;
   logic [IDW-1:0] ptr, sel;
   logic [PW-1:0] prime;
   logic primed, any;

   assign sync_out = chain[SYNC_STAGES*NUM_IN-1 -: NUM_IN];
   // edges stay masked until the chain and the history flop both hold post-reset samples
   assign primed = prime == PW'(SYNC_STAGES + 1);
   assign qual = primed ? ((sync_out & ~hist & rise_en) | (~sync_out & hist & fall_en)) : '0;
   // round robin: lowest pending bit above ptr, otherwise wrap to lowest pending bit
   assign hi = pending & ~((NUM_IN'(2) << ptr) - NUM_IN'(1));
   assign req = (|hi) ? hi : pending;
   assign oh = req & (~req + NUM_IN'(1));
   assign any = (~evt_valid | evt_ready) & (|pending);
   assign gnt = any ? oh : '0;

   for (genvar b = 0; b < IDW; b++) begin : g_id
      for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
         assign idm[b][i] = oh[i] & (((i >> b) & 1) == 1);
      end
      assign sel[b] = |idm[b];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain   <= '0;
         hist    <= '0;
         prime   <= '0;
         pending <= '0;
         level   <= '0;
         ovf     <= '0;
      end else begin
         chain   <= {chain[(SYNC_STAGES-1)*NUM_IN-1:0], in};
         hist    <= sync_out;
         prime   <= primed ? prime : prime + 1'b1;
         pending <= qual | (pending & ~gnt);
         // a grant takes the old data, so a same-cycle edge on the granted channel is not an overflow
         ovf     <= ~gnt & (ovf | (qual & pending));
         level   <= (qual & sync_out) | (~qual & level);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_level <= 1'b0;
         evt_ovf   <= 1'b0;
         ptr       <= '0;
      end else if (any) begin
         evt_valid <= 1'b1;
         evt_id    <= sel;
         evt_level <= |(oh & level);
         evt_ovf   <= |(oh & ovf);
         ptr       <= sel;
      end else if (evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

`ifdef WCA_SYNC_EVT_TIMESTAMP_EN
   logic [15:0] tcnt, tsel;
   // time latches stored bit-major so each timestamp bit is a per-channel vector
   logic [15:0][NUM_IN-1:0] tl, trep;

   for (genvar b = 0; b < 16; b++) begin : g_t
      assign trep[b] = {NUM_IN{tcnt[b]}};
      assign tsel[b] = |(oh & tl[b]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tcnt     <= '0;
         tl       <= '0;
         evt_time <= '0;
      end else begin
         tcnt <= tcnt + 16'd1;
         tl   <= ({16{qual}} & trep) | (~{16{qual}} & tl);
         if (any) evt_time <= tsel;
      end
   end
`else
   assign evt_time = 16'd0;
`endif

endmodule

// File: doc/wca_sync_event_arbiter.md
Name: wca_sync_event_arbiter

Overview:
Multi-channel input-event front end for the WCA control fabric. Each of NUM_IN asynchronous inputs passes through its own SYNC_STAGES-deep synchronizer chain, and rising and falling edges are detected per channel. Detected edges are queued as per-channel pending flags. A round-robin scheduler shares a single valid/ready event port among all channels. It feeds the register/interrupt logic that previously polled raw synchronized lines.

Parameters:
NUM_IN, 4, number of asynchronous input channels (2..16)
IDW, 2, event-ID width; must satisfy 2^IDW >= NUM_IN
SYNC_STAGES, 2, synchronizer flops per channel (2..4)

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
in  in  NUM_IN  raw asynchronous inputs
rise_en  in  NUM_IN  per-channel enable for rising-edge events; quasi-static
fall_en  in  NUM_IN  per-channel enable for falling-edge events; quasi-static
sync_out  out  NUM_IN  synchronized level (last synchronizer stage)
pending  out  NUM_IN  per-channel pending-event flags
evt_valid  out  1  event word valid
evt_ready  in  1  consumer accepts event when evt_valid & evt_ready
evt_id  out  IDW  channel index of the event
evt_level  out  1  synchronized level captured at edge detection (1 = rise, 0 = fall)
evt_ovf  out  1  one or more edges on this channel were lost before grant
evt_time  out  16  capture timestamp (see Optional Feature)

Behaviour:
- Reset: asserting reset_n low immediately clears all synchronizer flops, edge-history flops, pending, level/ovf latches, the round-robin pointer, and the prime counter. All outputs read 0 during reset and remain 0 until generated by a new event.
- Synchronizer: plain flop chain per channel. sync_out follows a stable `in` after SYNC_STAGES edges. No logic sits between stages.
- Prime window: after reset deassertion, edge detection is suppressed for SYNC_STAGES+1 cycles. A high input at reset release therefore creates no spurious rise event. Only the history flop is updated during this window.
- Edge detect: compare sync_out with a one-cycle-delayed copy. An edge is qualified by rise_en or fall_en for its direction.
- Pending set: a qualified edge sets pending[i] on the next edge, latches level[i] = sync_out[i] and, if enabled, the timestamp. Latency from a stable `in` to pending is SYNC_STAGES+1 edges.
- Overflow: a qualified edge while pending[i]=1 and channel i is not being granted that same cycle sets ovf[i]=1 and overwrites level/time with the newest values. pending stays 1.
- Grant/capture: the output register is free when evt_valid=0 or (evt_valid & evt_ready). When free and any pending is set, the scheduler picks the first set bit searching upward (wrapping) from ptr+1. It loads evt_id/evt_level/evt_ovf/evt_time, sets evt_valid, clears pending[i] and ovf[i], and sets ptr=i.
  - Pending to evt_valid takes 1 edge, for a total of SYNC_STAGES+2 edges from the input.
  - Back-to-back: accept and new grant can occur in the same cycle, giving 1 event per clock sustained.
- Simultaneous grant and new edge on the same channel: the grant takes the old data. pending[i] remains/re-sets with the new data, and ovf is NOT set.
- Output stability: while evt_valid=1 and evt_ready=0, all evt_* fields hold constant.
- If no pending and an accept occurs, evt_valid deasserts on the next edge.
- Changes to rise_en/fall_en affect only edges detected afterward. Pending flags are not cleared.

Optional Feature:
Macro WCA_SYNC_EVT_TIMESTAMP_EN.
- Defined: a 16-bit free-running counter runs, reset to 0, wrapping 0xFFFF->0x0000. Its value at the edge-detect cycle is latched per channel and presented on evt_time.
- Undefined: no counter and no per-channel time latches; evt_time is driven constant 0. The port list is unchanged.

Test Plan:
- Reset release with in=4'b0101, all enables 1 -> no evt_valid for 20 cycles; sync_out=4'b0101 after 2 cycles.
- Single rise on ch2, evt_ready=1 -> evt_valid exactly 4 edges after input change; evt_id=2, level=1, ovf=0, valid for 1 cycle.
- Simultaneous rises on ch0..ch3, ptr=0, evt_ready=1 -> ids 1,2,3,0 on consecutive cycles, 4 events, no gaps.
- evt_ready=0, ch1 toggles rise-fall-rise -> after ready=1: first event id=1 level=1 ovf=0 (already captured). The next event is id=1 level=1 ovf=1 (fall overwritten by rise).
- fall_en[3]=0, ch3 falls -> no event; sync_out[3]=0 after 2 cycles.
- With WCA_SYNC_EVT_TIMESTAMP_EN, edge detected at counter 0xFFFE, consumer stalls 5 cycles -> evt_time=0xFFFE held throughout the stall. Without the macro, evt_time=0 always.
